cpu_2a03: RTL and testbench

Cycle-stepped 8-bit CPU core implementing a defined subset of the NMOS 6502 instruction set as used in the NES 2A03. Binary arithmetic only: the D flag is stored but has no effect. The core drives a 16-bit address bus with one memory access per clock. It sits between the system memory/bus fabric and the on-chip I/O decode, and exposes the controller-port strobes for $4016/$4017.

---
 rtl/cpu_2a03.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cpu_2a03.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_2a03.sv
// cpu_2a03: cycle-stepped NMOS 6502-subset core as used in the NES 2A03 (binary ALU only).
// One bus access per clock; addr/rw/data_out are registered and describe the cycle in progress.
module cpu_2a03 (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rw,
    input  logic        nnmi,
    input  logic        nirq,
    output logic        naddr4016r,
    output logic        naddr4017r,
    output logic        addr4016w
);

    typedef enum logic [1:0] {S_VEC0, S_VEC1, S_RUN} state_t;
    typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ABS, M_JMP, M_REL} mode_t;
    typedef enum logic [4:0] {
        OP_NOP, OP_LDA, OP_LDX, OP_LDY, OP_STA, OP_STX, OP_STY,
        OP_ADC, OP_SBC, OP_AND, OP_ORA, OP_EOR, OP_CMP,
        OP_INX, OP_INY, OP_DEX, OP_DEY, OP_TAX, OP_TAY, OP_TXA, OP_TYA, OP_TXS, OP_TSX,
        OP_CLC, OP_SEC, OP_CLI, OP_SEI, OP_CLV, OP_CLD, OP_SED, OP_JMP, OP_BR
    } op_t;

    state_t      state_q, state_d;
    logic [15:0] PC, pc_d, addr_d;
    logic [7:0]  A, a_d, X, x_d, Y, y_d, SP, sp_d, flags, flags_d;
    logic [7:0]  IDL, idl_d, IR, ir_d, dout_d;
    logic [3:0]  cyc_count, cyc_d;
    logic        rw_d;

    op_t         op;
    mode_t       mode;
    logic        is_store, taken, flag_sel, set_nz, do_exec;
    logic [7:0]  store_val, m_eff, res;
    logic [7:0]  ex_a, ex_x, ex_y, ex_sp, ex_f;
    logic [8:0]  sum, diff;
    logic        unused_irq;

    assign unused_irq = nnmi & nirq;

    assign naddr4016r = ~((addr == 16'h4016) & rw);
    assign naddr4017r = ~((addr == 16'h4017) & rw);
    assign addr4016w  = (addr == 16'h4016) & ~rw;

    // Opcode decode from the latched instruction register.
    always_comb begin
        op = OP_NOP;
        case (IR)
            8'hA9, 8'hA5, 8'hAD: op = OP_LDA;
            8'hA2, 8'hA6, 8'hAE: op = OP_LDX;
            8'hA0, 8'hA4, 8'hAC: op = OP_LDY;
            8'h85, 8'h8D:        op = OP_STA;
            8'h86, 8'h8E:        op = OP_STX;
            8'h84, 8'h8C:        op = OP_STY;
            8'h69, 8'h65, 8'h6D: op = OP_ADC;
            8'hE9, 8'hE5, 8'hED: op = OP_SBC;
            8'h29, 8'h25, 8'h2D: op = OP_AND;
            8'h09, 8'h05, 8'h0D: op = OP_ORA;
            8'h49, 8'h45, 8'h4D: op = OP_EOR;
            8'hC9, 8'hC5, 8'hCD: op = OP_CMP;
            8'hE8: op = OP_INX;
            8'hC8: op = OP_INY;
            8'hCA: op = OP_DEX;
            8'h88: op = OP_DEY;
            8'hAA: op = OP_TAX;
            8'hA8: op = OP_TAY;
            8'h8A: op = OP_TXA;
            8'h98: op = OP_TYA;
            8'h9A: op = OP_TXS;
            8'hBA: op = OP_TSX;
            8'h18: op = OP_CLC;
            8'h38: op = OP_SEC;
            8'h58: op = OP_CLI;
            8'h78: op = OP_SEI;
            8'hB8: op = OP_CLV;
            8'hD8: op = OP_CLD;
            8'hF8: op = OP_SED;
            8'h4C: op = OP_JMP;
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: op = OP_BR;
            default: op = OP_NOP;
        endcase

        mode = M_IMP;
        if (op inside {OP_LDA, OP_LDX, OP_LDY, OP_STA, OP_STX, OP_STY,
                       OP_ADC, OP_SBC, OP_AND, OP_ORA, OP_EOR, OP_CMP}) begin
            case (IR[3:0])
                4'h0, 4'h2, 4'h9: mode = M_IMM;
                4'h4, 4'h5, 4'h6: mode = M_ZP;
                default:          mode = M_ABS;
            endcase
        end else if (op == OP_JMP) begin
            mode = M_JMP;
        end else if (op == OP_BR) begin
            mode = M_REL;
        end

        is_store  = op inside {OP_STA, OP_STX, OP_STY};
        store_val = (op == OP_STA) ? A : (op == OP_STX) ? X : (op == OP_STY) ? Y : 8'h00;

        // Branch opcodes encode the tested flag in IR[7:6] and the wanted value in IR[5].
        case (IR[7:6])
            2'd0:    flag_sel = flags[7];
            2'd1:    flag_sel = flags[6];
            2'd2:    flag_sel = flags[0];
            default: flag_sel = flags[1];
        endcase
        taken = (flag_sel == IR[5]);
    end

    // Register/flag results of executing op with memory operand data_in.
    always_comb begin
        ex_a   = A;
        ex_x   = X;
        ex_y   = Y;
        ex_sp  = SP;
        ex_f   = flags;
        res    = '0;
        set_nz = 1'b0;
        m_eff  = (op == OP_SBC) ? ~data_in : data_in;
        sum    = {1'b0, A} + {1'b0, m_eff} + {8'd0, flags[0]};
        diff   = {1'b0, A} - {1'b0, data_in};
        case (op)
            OP_LDA: begin res = data_in; ex_a = res; set_nz = 1'b1; end
            OP_LDX: begin res = data_in; ex_x = res; set_nz = 1'b1; end
            OP_LDY: begin res = data_in; ex_y = res; set_nz = 1'b1; end
            OP_ADC, OP_SBC: begin
                res     = sum[7:0];
                ex_a    = res;
                set_nz  = 1'b1;
                ex_f[0] = sum[8];
                ex_f[6] = (A[7] ^ res[7]) & (m_eff[7] ^ res[7]);
            end
            OP_AND: begin res = A & data_in; ex_a = res; set_nz = 1'b1; end
            OP_ORA: begin res = A | data_in; ex_a = res; set_nz = 1'b1; end
            OP_EOR: begin res = A ^ data_in; ex_a = res; set_nz = 1'b1; end
            OP_CMP: begin res = diff[7:0]; ex_f[0] = ~diff[8]; set_nz = 1'b1; end
            OP_INX: begin res = X + 8'd1; ex_x = res; set_nz = 1'b1; end
            OP_INY: begin res = Y + 8'd1; ex_y = res; set_nz = 1'b1; end
            OP_DEX: begin res = X - 8'd1; ex_x = res; set_nz = 1'b1; end
            OP_DEY: begin res = Y - 8'd1; ex_y = res; set_nz = 1'b1; end
            OP_TAX: begin res = A; ex_x = res; set_nz = 1'b1; end
            OP_TAY: begin res = A; ex_y = res; set_nz = 1'b1; end
            OP_TXA: begin res = X; ex_a = res; set_nz = 1'b1; end
            OP_TYA: begin res = Y; ex_a = res; set_nz = 1'b1; end
            OP_TSX: begin res = SP; ex_x = res; set_nz = 1'b1; end
            OP_TXS: ex_sp = X;
            OP_CLC: ex_f[0] = 1'b0;
            OP_SEC: ex_f[0] = 1'b1;
            OP_CLI: ex_f[2] = 1'b0;
            OP_SEI: ex_f[2] = 1'b1;
            OP_CLV: ex_f[6] = 1'b0;
            OP_CLD: ex_f[3] = 1'b0;
            OP_SED: ex_f[3] = 1'b1;
            default: ;
        endcase
        if (set_nz) begin
            ex_f[7] = res[7];
            ex_f[1] = (res == 8'h00);
        end
        ex_f[5] = 1'b1;
    end

    // Sequencer: decides this cycle's register updates and the next bus cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        a_d     = A;
        x_d     = X;
        y_d     = Y;
        sp_d    = SP;
        flags_d = flags;
        idl_d   = IDL;
        ir_d    = IR;
        cyc_d   = cyc_count;
        addr_d  = PC;
        rw_d    = 1'b1;
        dout_d  = '0;
        do_exec = 1'b0;
        case (state_q)
            S_VEC0: begin
                idl_d   = data_in;
                addr_d  = 16'hFFFD;
                state_d = S_VEC1;
            end
            S_VEC1: begin
                pc_d    = {data_in, IDL};
                addr_d  = {data_in, IDL};
                cyc_d   = '0;
                state_d = S_RUN;
            end
            default: begin
                case (cyc_count)
                    4'd0: begin
                        ir_d   = data_in;
                        pc_d   = PC + 16'd1;
                        addr_d = PC + 16'd1;
                        cyc_d  = 4'd1;
                    end
                    4'd1: begin
                        cyc_d = 4'd0;
                        case (mode)
                            M_IMP: do_exec = 1'b1;
                            M_IMM: begin
                                do_exec = 1'b1;
                                pc_d    = PC + 16'd1;
                                addr_d  = PC + 16'd1;
                            end
                            M_ZP: begin
                                idl_d  = data_in;
                                pc_d   = PC + 16'd1;
                                addr_d = {8'h00, data_in};
                                rw_d   = ~is_store;
                                dout_d = store_val;
                                cyc_d  = 4'd2;
                            end
                            default: begin
                                idl_d  = data_in;
                                pc_d   = PC + 16'd1;
                                addr_d = PC + 16'd1;
                                cyc_d  = (mode != M_REL || taken) ? 4'd2 : 4'd0;
                            end
                        endcase
                    end
                    4'd2: begin
                        cyc_d = 4'd0;
                        case (mode)
                            M_ZP: do_exec = 1'b1;
                            M_ABS: begin
                                pc_d   = PC + 16'd1;
                                addr_d = {data_in, IDL};
                                rw_d   = ~is_store;
                                dout_d = store_val;
                                cyc_d  = 4'd3;
                            end
                            M_JMP: begin
                                pc_d   = {data_in, IDL};
                                addr_d = {data_in, IDL};
                            end
                            M_REL: begin
                                pc_d   = PC + {{8{IDL[7]}}, IDL};
                                addr_d = PC + {{8{IDL[7]}}, IDL};
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        do_exec = 1'b1;
                        cyc_d   = 4'd0;
                    end
                endcase
            end
        endcase
        if (!rw_d) begin
            dout_d = store_val;
        end else begin
            dout_d = '0;
        end
        if (do_exec) begin
            a_d     = ex_a;
            x_d     = ex_x;
            y_d     = ex_y;
            sp_d    = ex_sp;
            flags_d = ex_f;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_VEC0;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            PC        <= '0;
            A         <= '0;
            X         <= '0;
            Y         <= '0;
            SP        <= 8'hFD;
            flags     <= 8'h24;
            IDL       <= '0;
            IR        <= '0;
            cyc_count <= '0;
            addr      <= 16'hFFFC;
            rw        <= 1'b1;
            data_out  <= '0;
        end else begin
            PC        <= pc_d;
            A         <= a_d;
            X         <= x_d;
            Y         <= y_d;
            SP        <= sp_d;
            flags     <= flags_d;
            IDL       <= idl_d;
            IR        <= ir_d;
            cyc_count <= cyc_d;
            addr      <= addr_d;
            rw        <= rw_d;
            data_out  <= dout_d;
        end
    end

endmodule

// File: tb/tb_cpu_2a03.sv
// Self-checking bench for cpu_2a03: directed programs plus random programs checked
// cycle-by-cycle against an instruction-level reference interpreter with its own memory copy.
module tb_cpu_2a03;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr;
    logic [7:0]  data_in, data_out;
    logic        rw, nnmi, nirq;
    logic        naddr4016r, naddr4017r, addr4016w;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  rmem [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
    } bus_t;
    bus_t        exp_q[$];

    logic [15:0] mpc;
    logic [7:0]  ma, mx, my, msp, mf;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  menu [62];

    cpu_2a03 dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .rw         (rw),
        .nnmi       (nnmi),
        .nirq       (nirq),
        .naddr4016r (naddr4016r),
        .naddr4017r (naddr4017r),
        .addr4016w  (addr4016w)
    );

    always #5 clock = ~clock;

    assign data_in = mem[addr];

    always @(negedge clock) begin
        if (!rw) mem[addr] = data_out;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        mem[a]  = v;
        rmem[a] = v;
    endtask

    task automatic load(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) wr(16'h8000 + 16'(i), v[8*(n-1-i) +: 8]);
        wr(16'hFFFC, 8'h00);
        wr(16'hFFFD, 8'h80);
    endtask

    // ---------------- reference interpreter ----------------
    function automatic int mode_of(input logic [7:0] op);
        if (op inside {8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9}) return 1;
        if (op inside {8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84,
                       8'h65, 8'hE5, 8'h25, 8'h05, 8'h45, 8'hC5}) return 2;
        if (op inside {8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C,
                       8'h6D, 8'hED, 8'h2D, 8'h0D, 8'h4D, 8'hCD}) return 3;
        if (op == 8'h4C) return 4;
        if (op inside {8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0}) return 5;
        return 0;
    endfunction

    function automatic logic m_taken(input logic [7:0] op);
        case (op)
            8'h10: return !mf[7];
            8'h30: return mf[7];
            8'h50: return !mf[6];
            8'h70: return mf[6];
            8'h90: return !mf[0];
            8'hB0: return mf[0];
            8'hD0: return !mf[1];
            default: return mf[1];
        endcase
    endfunction

    task automatic setnz(input logic [7:0] r);
        mf[7] = r[7];
        mf[1] = (r == 8'h00);
    endtask

    task automatic m_exec(input logic [7:0] op, input logic [7:0] m);
        int s;
        logic [7:0] mm, r;
        if (op inside {8'hA9, 8'hA5, 8'hAD}) begin ma = m; setnz(ma); end
        else if (op inside {8'hA2, 8'hA6, 8'hAE}) begin mx = m; setnz(mx); end
        else if (op inside {8'hA0, 8'hA4, 8'hAC}) begin my = m; setnz(my); end
        else if (op inside {8'h69, 8'h65, 8'h6D, 8'hE9, 8'hE5, 8'hED}) begin
            mm = (op inside {8'hE9, 8'hE5, 8'hED}) ? ~m : m;
            s  = int'(ma) + int'(mm) + int'(mf[0]);
            r  = 8'(s);
            mf[0] = (s > 255);
            mf[6] = (((ma ^ r) & (mm ^ r) & 8'h80) != 8'h00);
            ma = r;
            setnz(ma);
        end
        else if (op inside {8'h29, 8'h25, 8'h2D}) begin ma = ma & m; setnz(ma); end
        else if (op inside {8'h09, 8'h05, 8'h0D}) begin ma = ma | m; setnz(ma); end
        else if (op inside {8'h49, 8'h45, 8'h4D}) begin ma = ma ^ m; setnz(ma); end
        else if (op inside {8'hC9, 8'hC5, 8'hCD}) begin
            r = ma - m;
            mf[0] = (ma >= m);
            mf[7] = r[7];
            mf[1] = (ma == m);
        end
        else case (op)
            8'hE8: begin mx = mx + 8'd1; setnz(mx); end
            8'hC8: begin my = my + 8'd1; setnz(my); end
            8'hCA: begin mx = mx - 8'd1; setnz(mx); end
            8'h88: begin my = my - 8'd1; setnz(my); end
            8'hAA: begin mx = ma; setnz(mx); end
            8'hA8: begin my = ma; setnz(my); end
            8'h8A: begin ma = mx; setnz(ma); end
            8'h98: begin ma = my; setnz(ma); end
            8'h9A: msp = mx;
            8'hBA: begin mx = msp; setnz(mx); end
            8'h18: mf[0] = 1'b0;
            8'h38: mf[0] = 1'b1;
            8'h58: mf[2] = 1'b0;
            8'h78: mf[2] = 1'b1;
            8'hB8: mf[6] = 1'b0;
            8'hD8: mf[3] = 1'b0;
            8'hF8: mf[3] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic push(input logic [15:0] a, input logic r, input logic [7:0] d);
        bus_t e;
        e.a = a; e.rw = r; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic m_access(input logic [7:0] op, input logic [15:0] ea);
        logic [7:0] v;
        if (op inside {8'h85, 8'h8D, 8'h86, 8'h8E, 8'h84, 8'h8C}) begin
            v = (op inside {8'h85, 8'h8D}) ? ma : (op inside {8'h86, 8'h8E}) ? mx : my;
            push(ea, 1'b0, v);
            rmem[ea] = v;
        end else begin
            push(ea, 1'b1, 8'h00);
            m_exec(op, rmem[ea]);
        end
    endtask

    task automatic model_step();
        logic [7:0] op, lo, hi;
        exp_q.delete();
        op = rmem[mpc];
        push(mpc, 1'b1, 8'h00);
        mpc++;
        case (mode_of(op))
            0: begin push(mpc, 1'b1, 8'h00); m_exec(op, 8'h00); end
            1: begin push(mpc, 1'b1, 8'h00); m_exec(op, rmem[mpc]); mpc++; end
            2: begin lo = rmem[mpc]; push(mpc, 1'b1, 8'h00); mpc++; m_access(op, {8'h00, lo}); end
            3: begin
                lo = rmem[mpc]; push(mpc, 1'b1, 8'h00); mpc++;
                hi = rmem[mpc]; push(mpc, 1'b1, 8'h00); mpc++;
                m_access(op, {hi, lo});
            end
            4: begin
                lo = rmem[mpc]; push(mpc, 1'b1, 8'h00); mpc++;
                hi = rmem[mpc]; push(mpc, 1'b1, 8'h00);
                mpc = {hi, lo};
            end
            default: begin
                lo = rmem[mpc]; push(mpc, 1'b1, 8'h00); mpc++;
                if (m_taken(op)) begin
                    push(mpc, 1'b1, 8'h00);
                    mpc = mpc + {{8{lo[7]}}, lo};
                end
            end
        endcase
    endtask

    task automatic m_reset();
        ma = 8'h00; mx = 8'h00; my = 8'h00; msp = 8'hFD; mf = 8'h24;
        mpc = {rmem[16'hFFFD], rmem[16'hFFFC]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic chk_state();
        chk("pc", dut.PC, mpc);
        chk("a", 16'(dut.A), 16'(ma));
        chk("x", 16'(dut.X), 16'(mx));
        chk("y", 16'(dut.Y), 16'(my));
        chk("sp", 16'(dut.SP), 16'(msp));
        chk("flags", 16'(dut.flags), 16'(mf));
        chk("cyc0", 16'(dut.cyc_count), 16'h0);
        chk("fetch_addr", addr, mpc);
    endtask

    task automatic step(output int ncyc, output int wr_at, output int r16_at, output int w16_at);
        bus_t e;
        model_step();
        ncyc = exp_q.size();
        wr_at = -1; r16_at = -1; w16_at = -1;
        for (int i = 0; i < ncyc; i++) begin
            e = exp_q[i];
            chk("addr", addr, e.a);
            chk("rw", 16'(rw), 16'(e.rw));
            chk("dout", 16'(data_out), 16'(e.d));
            chk("n4016r", 16'(naddr4016r), 16'(!(e.a == 16'h4016 && e.rw)));
            chk("n4017r", 16'(naddr4017r), 16'(!(e.a == 16'h4017 && e.rw)));
            chk("a4016w", 16'(addr4016w), 16'(e.a == 16'h4016 && !e.rw));
            if (!rw) wr_at = i;
            if (!naddr4016r) r16_at = i;
            if (addr4016w) w16_at = i;
            tick();
        end
        chk_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_addr", addr, 16'hFFFC);
            chk("rst_rw", 16'(rw), 16'h1);
            chk("rst_pc", dut.PC, 16'h0);
            chk("rst_axy", {8'h00, dut.A | dut.X | dut.Y}, 16'h0);
            chk("rst_sp", 16'(dut.SP), 16'hFD);
            chk("rst_flags", 16'(dut.flags), 16'h24);
            chk("rst_idl", 16'(dut.IDL), 16'h0);
            chk("rst_cyc", 16'(dut.cyc_count), 16'h0);
        end
        reset = 1'b0;
        m_reset();
        chk("v0_addr", addr, 16'hFFFC);
        tick();
        chk("v1_addr", addr, 16'hFFFD);
        tick();
        chk("vec_fetch", addr, mpc);
        chk("vec_cyc", 16'(dut.cyc_count), 16'h0);
    endtask

    task automatic abort_mid();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_addr", addr, 16'hFFFC);
        chk("abort_rw", 16'(rw), 16'h1);
        chk("abort_cyc", 16'(dut.cyc_count), 16'h0);
        do_reset();
    endtask

    task automatic gen_prog();
        int p;
        logic [7:0] op, lo, hi;
        p = 0;
        while (p < 240) begin
            op = menu[$urandom_range(0, 61)];
            wr(16'h8000 + 16'(p), op);
            p++;
            lo = 8'($urandom);
            hi = 8'h80;
            case (mode_of(op))
                1, 2: begin wr(16'h8000 + 16'(p), lo); p++; end
                3: begin
                    case ($urandom_range(0, 3))
                        0: hi = 8'h02;
                        1: begin hi = 8'h40; lo = 8'h16 + 8'($urandom_range(0, 1)); end
                        2: hi = 8'h80;
                        default: hi = 8'($urandom);
                    endcase
                    wr(16'h8000 + 16'(p), lo);
                    wr(16'h8001 + 16'(p), hi);
                    p += 2;
                end
                4: begin
                    wr(16'h8000 + 16'(p), 8'($urandom_range(0, 239)));
                    wr(16'h8001 + 16'(p), 8'h80);
                    p += 2;
                end
                5: begin wr(16'h8000 + 16'(p), 8'($urandom_range(0, 16)) - 8'd8); p++; end
                default: ;
            endcase
        end
        wr(16'hFFFC, 8'h00);
        wr(16'hFFFD, 8'h80);
    endtask

    initial begin
        int n, w, r, ww;
        logic [7:0] v;
        nnmi = 1'b1;
        nirq = 1'b1;
        menu = '{8'hA9, 8'hA5, 8'hAD, 8'hA2, 8'hA6, 8'hAE, 8'hA0, 8'hA4, 8'hAC,
                 8'h85, 8'h8D, 8'h86, 8'h8E, 8'h84, 8'h8C,
                 8'h69, 8'h65, 8'h6D, 8'hE9, 8'hE5, 8'hED, 8'h29, 8'h25, 8'h2D,
                 8'h09, 8'h05, 8'h0D, 8'h49, 8'h45, 8'h4D, 8'hC9, 8'hC5, 8'hCD,
                 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h9A, 8'hBA,
                 8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hD8, 8'hF8, 8'hEA, 8'h4C,
                 8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h02, 8'hFF};
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i]  = v;
            rmem[i] = v;
        end

        // Reset vector, then LDA #$31 / STA $0200
        load(64'hA9318D0002, 5);
        do_reset();
        chk("vec_pc", dut.PC, 16'h8000);
        step(n, w, r, ww);
        chk("lda_cycles", 16'(n), 16'd2);
        step(n, w, r, ww);
        chk("sta_cycles", 16'(n), 16'd4);
        chk("sta_write_cyc", 16'(w), 16'd3);
        chk("mem_0200", 16'(mem[16'h0200]), 16'h31);

        // ADC signed overflow
        load(64'h18A9506950, 5);
        do_reset();
        for (int i = 0; i < 3; i++) step(n, w, r, ww);
        chk("adc_a", 16'(dut.A), 16'hA0);
        chk("adc_nvzc", 16'({dut.flags[7], dut.flags[6], dut.flags[1], dut.flags[0]}), 16'b1100);

        // SBC borrow
        load(64'h38A900E901, 5);
        do_reset();
        for (int i = 0; i < 3; i++) step(n, w, r, ww);
        chk("sbc_a", 16'(dut.A), 16'hFF);
        chk("sbc_c", 16'(dut.flags[0]), 16'h0);
        chk("sbc_n", 16'(dut.flags[7]), 16'h1);

        // DEX/BNE loop
        load(64'hA203CAD0FD, 5);
        do_reset();
        step(n, w, r, ww);
        for (int k = 0; k < 3; k++) begin
            step(n, w, r, ww);
            chk("dex_cycles", 16'(n), 16'd2);
            step(n, w, r, ww);
            chk("bne_cycles", 16'(n), (k < 2) ? 16'd3 : 16'd2);
        end
        chk("loop_x", 16'(dut.X), 16'h0);
        chk("loop_z", 16'(dut.flags[1]), 16'h1);
        chk("loop_pc", dut.PC, 16'h8005);

        // $4016 strobes, then unlisted opcode $02
        load(64'hAD16408D164002, 7);
        do_reset();
        step(n, w, r, ww);
        chk("r4016_cyc", 16'(r), 16'd3);
        chk("r4016_nowr", 16'(ww), 16'hFFFF);
        step(n, w, r, ww);
        chk("w4016_cyc", 16'(ww), 16'd3);
        chk("w4016_noread", 16'(r), 16'hFFFF);
        step(n, w, r, ww);
        chk("op02_cycles", 16'(n), 16'd2);
        chk("op02_pc", dut.PC, 16'h8007);

        // Random programs against the reference interpreter
        for (int rep = 0; rep < 4; rep++) begin
            gen_prog();
            do_reset();
            for (int k = 0; k < 80; k++) begin
                step(n, w, r, ww);
                if (rep == 1 && k == 40) abort_mid();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
